tff_bist_engine: RTL and testbench



---
 rtl/tff_bist_pkg.sv | 22 ++
 rtl/bist_misr.sv | 34 +++
 rtl/tff_bist_engine.sv | 151 +++++++++++++++
 tb/tb_tff_bist_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_bist_pkg.sv
// Shared definitions for the TFF BIST engine: FSM state encoding, default
// LFSR/MISR polynomials and the signature/counter widths.
package tff_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned SIG_W      = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LFSR_W_DEF = 8;

  localparam logic [7:0]       LFSR_SEED_DEF = 8'hA5;
  localparam logic [7:0]       LFSR_TAPS_DEF = 8'hB8;
  localparam logic [SIG_W-1:0] MISR_TAPS_DEF = 16'h1021;

endpackage

// File: rtl/bist_misr.sv
// Single-input signature register: shift left, fold the polynomial in when the
// MSB falls out, XOR the response bit into bit 0.
// Ports:
//   clk   - rising-edge clock
//   clear - asynchronous active-high reset (signature -> 0)
//   init  - synchronous clear of the signature
//   en    - absorb din on this edge
//   din   - response bit to compact
//   sig   - current signature
module bist_misr
  import tff_bist_pkg::*;
#(
  parameter int unsigned    W    = SIG_W,
  parameter logic [W-1:0]   TAPS = W'(MISR_TAPS_DEF)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         init,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] sig
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sig <= '0;
    end else if (init) begin
      sig <= '0;
    end else if (en) begin
      sig <= ({sig[W-2:0], 1'b0} ^ (sig[W-1] ? TAPS : W'(0))) ^ {{(W-1){1'b0}}, din};
    end
  end

endmodule

// File: rtl/tff_bist_engine.sv
// BIST engine for a toggle flip-flop CUT: clears the CUT, drives LFSR patterns
// on T, compacts q into a MISR and compares the result with a golden value.
// Ports:
//   clk       - rising-edge clock
//   clear     - asynchronous active-high reset
//   start     - begin a test (sampled in IDLE or DONE only)
//   cut_q     - CUT flip-flop output
//   cut_t     - T input to the CUT
//   cut_clear - clear to the CUT (engine reset or INIT cycle)
//   busy      - test in progress
//   done      - result available
//   pass      - signature matched GOLDEN_SIG (valid with done)
//   signature - final MISR contents (valid with done)
module tff_bist_engine
  import tff_bist_pkg::*;
#(
  parameter int unsigned        LFSR_W        = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0]  LFSR_SEED     = LFSR_W'(LFSR_SEED_DEF),
  parameter logic [LFSR_W-1:0]  LFSR_TAPS     = LFSR_W'(LFSR_TAPS_DEF),
  parameter int unsigned        MISR_W        = SIG_W,
  parameter logic [MISR_W-1:0]  MISR_TAPS     = MISR_W'(MISR_TAPS_DEF),
  parameter int unsigned        PATTERN_COUNT = 255,
  parameter logic [MISR_W-1:0]  GOLDEN_SIG    = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              cut_q,
  output logic              cut_t,
  output logic              cut_clear,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERN_COUNT - 32'd1);

  state_t              state;
  state_t              state_nxt;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    count;
  logic                init_q;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                misr_init;
  logic                misr_en;
  logic                cmp_load;
  logic [MISR_W-1:0]   misr_sig;

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    misr_init = 1'b0;
    misr_en   = 1'b0;
    cmp_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        lfsr_load = 1'b1;
        misr_init = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        lfsr_step = 1'b1;
        // q lags t by one cycle: the first RUN edge sees the post-clear q.
        misr_en   = (count != '0);
        if (count == LAST_CNT) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        misr_en   = 1'b1;
        state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        cmp_load  = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_nxt = ST_INIT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pattern LFSR and applied-vector counter
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      lfsr  <= LFSR_SEED;
      count <= '0;
    end else if (lfsr_load) begin
      lfsr  <= LFSR_SEED;
      count <= '0;
    end else if (lfsr_step) begin
      lfsr  <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
      count <= count + CNT_W'(1);
    end
  end

  // Response compactor
  bist_misr #(
    .W    (MISR_W),
    .TAPS (MISR_TAPS)
  ) u_misr (
    .clk   (clk),
    .clear (clear),
    .init  (misr_init),
    .en    (misr_en),
    .din   (cut_q),
    .sig   (misr_sig)
  );

  // Registered status/result outputs, decoded from the upcoming state
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      init_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      init_q <= (state_nxt == ST_INIT);
      busy   <= (state_nxt inside {ST_INIT, ST_RUN, ST_FLUSH, ST_COMPARE});
      done   <= (state_nxt == ST_DONE);
      if (cmp_load) begin
        signature <= misr_sig;
        pass      <= (misr_sig == GOLDEN_SIG);
      end else if (state_nxt == ST_INIT) begin
        pass <= 1'b0;
      end
    end
  end

  assign cut_t     = (state == ST_RUN) & lfsr[0];
  assign cut_clear = clear | init_q;

endmodule

// File: tb/tb_tff_bist_engine.sv
// Bench for tff_bist_engine: several engines side by side with a good TFF, an
// inverted TFF, stuck-at-0 and random responses, checked against a
// behavioural model of the pattern/TFF/signature chain.
module tb_tff_bist_engine;

  // ---------------- reference model ----------------
  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic b);
    logic [15:0] r;
    r = {m[14:0], 1'b0};
    if (m[15]) r = r ^ 16'h1021;
    return r ^ {15'b0, b};
  endfunction

  // Signature of a good (or inverted) TFF driven by pc LFSR vectors from reset.
  function automatic logic [15:0] model_sig(input int pc, input bit inv);
    logic [7:0]  l;
    logic        q;
    logic [15:0] m;
    l = 8'hA5;
    q = 1'b0;
    m = 16'h0000;
    for (int i = 0; i < pc; i++) begin
      q = q ^ l[0];
      m = misr_step(m, q ^ inv);
      l = {l[6:0], ^(l & 8'hB8)};
    end
    return m;
  endfunction

  localparam logic [15:0] GOOD8 = model_sig(8, 1'b0);
  localparam logic [15:0] GOOD1 = model_sig(1, 1'b0);

  // ---------------- signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clear, start, poke, start_g;
  logic rnd_q;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   hist [0:4095];

  assign start_g = start | poke;

  logic t_g, cc_g, busy_g, done_g, pass_g, q_g;   logic [15:0] sig_g;
  logic t_i, cc_i, busy_i, done_i, pass_i, q_i;   logic [15:0] sig_i;
  logic t_1, cc_1, busy_1, done_1, pass_1, q_1;   logic [15:0] sig_1;
  logic t_z, cc_z, busy_z, done_z, pass_z;        logic [15:0] sig_z;
  logic t_y, cc_y, busy_y, done_y, pass_y;        logic [15:0] sig_y;
  logic t_r, cc_r, busy_r, done_r, pass_r;        logic [15:0] sig_r;

  // behavioural CUTs
  always @(posedge clk or posedge cc_g) if (cc_g) q_g <= 1'b0; else if (t_g) q_g <= ~q_g;
  always @(posedge clk or posedge cc_i) if (cc_i) q_i <= 1'b0; else if (t_i) q_i <= ~q_i;
  always @(posedge clk or posedge cc_1) if (cc_1) q_1 <= 1'b0; else if (t_1) q_1 <= ~q_1;

  // random response stream with per-edge history
  always @(negedge clk) rnd_q <= 1'($urandom);
  always @(posedge clk) begin
    if (cyc < 4096) hist[cyc] <= rnd_q;
    cyc <= cyc + 1;
  end

  tff_bist_engine #(.PATTERN_COUNT(8), .GOLDEN_SIG(GOOD8)) dut_g (
    .clk(clk), .clear(clear), .start(start_g), .cut_q(q_g), .cut_t(t_g), .cut_clear(cc_g),
    .busy(busy_g), .done(done_g), .pass(pass_g), .signature(sig_g));
  tff_bist_engine #(.PATTERN_COUNT(8), .GOLDEN_SIG(GOOD8)) dut_i (
    .clk(clk), .clear(clear), .start(start), .cut_q(~q_i), .cut_t(t_i), .cut_clear(cc_i),
    .busy(busy_i), .done(done_i), .pass(pass_i), .signature(sig_i));
  tff_bist_engine #(.PATTERN_COUNT(1), .GOLDEN_SIG(GOOD1)) dut_1 (
    .clk(clk), .clear(clear), .start(start), .cut_q(q_1), .cut_t(t_1), .cut_clear(cc_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1));
  tff_bist_engine #(.PATTERN_COUNT(8), .GOLDEN_SIG(16'h0000)) dut_z (
    .clk(clk), .clear(clear), .start(start), .cut_q(1'b0), .cut_t(t_z), .cut_clear(cc_z),
    .busy(busy_z), .done(done_z), .pass(pass_z), .signature(sig_z));
  tff_bist_engine #(.PATTERN_COUNT(8), .GOLDEN_SIG(GOOD8)) dut_y (
    .clk(clk), .clear(clear), .start(start), .cut_q(1'b0), .cut_t(t_y), .cut_clear(cc_y),
    .busy(busy_y), .done(done_y), .pass(pass_y), .signature(sig_y));
  tff_bist_engine #(.PATTERN_COUNT(8), .GOLDEN_SIG(16'h0000)) dut_r (
    .clk(clk), .clear(clear), .start(start), .cut_q(rnd_q), .cut_t(t_r), .cut_clear(cc_r),
    .busy(busy_r), .done(done_r), .pass(pass_r), .signature(sig_r));

  // Pulse start, then observe dut_g/dut_1 at each falling edge; c counts edges after E0.
  task automatic run_once(input int ign_at, output int done_at, output int one_at,
                          output int clr_cnt, output int busy_cnt, output int g0,
                          output bit done_c0, output logic [15:0] tbits);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    g0       = cyc - 1;
    done_at  = -1;
    one_at   = -1;
    clr_cnt  = 0;
    busy_cnt = 0;
    tbits    = '0;
    done_c0  = done_g;
    for (int c = 0; c < 40 && done_at < 0; c++) begin
      if (c > 0) @(negedge clk);
      poke = (c == ign_at);
      if (c < 16) tbits[c] = t_g;
      if (cc_g) clr_cnt++;
      if (busy_g) busy_cnt++;
      if (done_g && done_at < 0) done_at = c;
      if (done_1 && one_at < 0) one_at = c;
    end
    poke = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; poke = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy_g !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_g); end
    n_chk++; if (done_g !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_g); end
    n_chk++; if (pass_g !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b want 0", pass_g); end
    n_chk++; if (sig_g !== 16'h0000) begin n_fail++; $display("FAIL reset_sig: got %h want 0000", sig_g); end
    n_chk++; if (t_g !== 1'b0) begin n_fail++; $display("FAIL reset_cut_t: got %b want 0", t_g); end
    n_chk++; if (cc_g !== 1'b1) begin n_fail++; $display("FAIL reset_cut_clear_in: got %b want 1", cc_g); end
    clear = 1'b0;
    #1;
    n_chk++; if (cc_g !== 1'b0) begin n_fail++; $display("FAIL reset_cut_clear_out: got %b want 0", cc_g); end
  endtask

  task automatic test_golden();
    int da, oa, cc, bc, g0; bit d0; logic [15:0] tb, texp; logic [7:0] l;
    texp = '0; l = 8'hA5;
    for (int i = 0; i < 8; i++) begin texp[i+1] = l[0]; l = {l[6:0], ^(l & 8'hB8)}; end
    for (int it = 0; it < 2; it++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_once(-1, da, oa, cc, bc, g0, d0, tb);
      n_chk++; if (da !== 11) begin n_fail++; $display("FAIL golden_done_at: got %0d want 11", da); end
      n_chk++; if (cc !== 1) begin n_fail++; $display("FAIL golden_clear_cycles: got %0d want 1", cc); end
      n_chk++; if (bc !== 11) begin n_fail++; $display("FAIL golden_busy_cycles: got %0d want 11", bc); end
      n_chk++; if (tb[10:0] !== texp[10:0]) begin n_fail++; $display("FAIL golden_t_seq: got %b want %b", tb[10:0], texp[10:0]); end
      n_chk++; if (sig_g !== GOOD8) begin n_fail++; $display("FAIL golden_sig: got %h want %h", sig_g, GOOD8); end
      n_chk++; if (pass_g !== 1'b1) begin n_fail++; $display("FAIL golden_pass: got %b want 1", pass_g); end
      n_chk++; if (oa !== 4) begin n_fail++; $display("FAIL pc1_done_at: got %0d want 4", oa); end
      n_chk++; if (sig_1 !== GOOD1) begin n_fail++; $display("FAIL pc1_sig: got %h want %h", sig_1, GOOD1); end
      n_chk++; if (pass_1 !== 1'b1) begin n_fail++; $display("FAIL pc1_pass: got %b want 1", pass_1); end
    end
  endtask

  task automatic test_faults();
    int da, oa, cc, bc, g0; bit d0; logic [15:0] tb, inv_exp;
    inv_exp = model_sig(8, 1'b1);
    run_once(-1, da, oa, cc, bc, g0, d0, tb);
    n_chk++; if (sig_i !== inv_exp) begin n_fail++; $display("FAIL inv_sig: got %h want %h", sig_i, inv_exp); end
    n_chk++; if (sig_i === GOOD8) begin n_fail++; $display("FAIL inv_sig_differs: got %h must differ from %h", sig_i, GOOD8); end
    n_chk++; if (pass_i !== 1'b0) begin n_fail++; $display("FAIL inv_pass: got %b want 0", pass_i); end
    n_chk++; if (sig_z !== 16'h0000) begin n_fail++; $display("FAIL s0_sig: got %h want 0000", sig_z); end
    n_chk++; if (pass_z !== 1'b1) begin n_fail++; $display("FAIL s0_pass: got %b want 1", pass_z); end
    n_chk++; if (pass_y !== (GOOD8 == 16'h0000)) begin n_fail++; $display("FAIL s0_golden_pass: got %b want %b", pass_y, GOOD8 == 16'h0000); end
    n_chk++; if (done_y !== 1'b1 || busy_z !== 1'b0) begin n_fail++; $display("FAIL s0_status: got done=%b busy=%b want 1/0", done_y, busy_z); end
  endtask

  task automatic test_random();
    int da, oa, cc, bc, g0; bit d0; logic [15:0] tb, m;
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_once(-1, da, oa, cc, bc, g0, d0, tb);
      m = 16'h0000;
      for (int k = 3; k <= 10; k++) m = misr_step(m, hist[g0+k]);
      n_chk++; if (sig_r !== m) begin n_fail++; $display("FAIL rnd_sig[%0d]: got %h want %h", it, sig_r, m); end
      n_chk++; if (pass_r !== (m == 16'h0000)) begin n_fail++; $display("FAIL rnd_pass[%0d]: got %b want %b", it, pass_r, m == 16'h0000); end
    end
  endtask

  task automatic test_start_ignored();
    int da, oa, cc, bc, g0, ign; bit d0; logic [15:0] tb;
    for (int it = 0; it < 2; it++) begin
      ign = $urandom_range(1, 8);
      run_once(ign, da, oa, cc, bc, g0, d0, tb);
      n_chk++; if (da !== 11) begin n_fail++; $display("FAIL ignore_done_at(poke %0d): got %0d want 11", ign, da); end
      n_chk++; if (bc !== 11) begin n_fail++; $display("FAIL ignore_busy(poke %0d): got %0d want 11", ign, bc); end
      n_chk++; if (sig_g !== GOOD8) begin n_fail++; $display("FAIL ignore_sig(poke %0d): got %h want %h", ign, sig_g, GOOD8); end
    end
  endtask

  task automatic test_restart();
    int da, oa, cc, bc, g0; bit d0; logic [15:0] tb;
    n_chk++; if (done_g !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done: got %b want 1", done_g); end
    run_once(-1, da, oa, cc, bc, g0, d0, tb);
    n_chk++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL restart_done_drop: got %b want 0", d0); end
    n_chk++; if (da !== 11) begin n_fail++; $display("FAIL restart_done_at: got %0d want 11", da); end
    n_chk++; if (sig_g !== GOOD8 || pass_g !== 1'b1) begin n_fail++; $display("FAIL restart_result: got %h/%b want %h/1", sig_g, pass_g, GOOD8); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    logic [24:0] dmask, dexp;
    dmask = '0; dexp = '0; dexp[11] = 1'b1; dexp[23] = 1'b1;
    n_done = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      @(negedge clk);
      dmask[c] = done_g;
      if (done_g) begin
        n_done++;
        n_chk++; if (pass_g !== 1'b1 || sig_g !== GOOD8) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h/%b want %h/1", c, sig_g, pass_g, GOOD8); end
      end
    end
    start = 1'b0;
    n_chk++; if (dmask !== dexp) begin n_fail++; $display("FAIL b2b_done_pattern: got %b want %b", dmask, dexp); end
    n_chk++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", n_done); end
    for (int c = 0; c < 40 && !done_g; c++) @(negedge clk);
    n_chk++; if (done_g !== 1'b1) begin n_fail++; $display("FAIL b2b_settle: got done=%b want 1", done_g); end
  endtask

  task automatic test_clear_mid();
    int da, oa, cc, bc, g0; bit d0; logic [15:0] tb;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (busy_g !== 1'b1) begin n_fail++; $display("FAIL clrmid_pre_busy: got %b want 1", busy_g); end
    clear = 1'b1;
    #1;
    n_chk++; if (busy_g !== 1'b0 || done_g !== 1'b0 || pass_g !== 1'b0) begin n_fail++; $display("FAIL clrmid_status: got busy=%b done=%b pass=%b want 0/0/0", busy_g, done_g, pass_g); end
    n_chk++; if (sig_g !== 16'h0000) begin n_fail++; $display("FAIL clrmid_sig: got %h want 0000", sig_g); end
    n_chk++; if (t_g !== 1'b0 || cc_g !== 1'b1) begin n_fail++; $display("FAIL clrmid_cut: got t=%b clear=%b want 0/1", t_g, cc_g); end
    @(negedge clk) clear = 1'b0;
    run_once(-1, da, oa, cc, bc, g0, d0, tb);
    n_chk++; if (da !== 11) begin n_fail++; $display("FAIL clrmid_rerun_done_at: got %0d want 11", da); end
    n_chk++; if (sig_g !== GOOD8 || pass_g !== 1'b1) begin n_fail++; $display("FAIL clrmid_rerun: got %h/%b want %h/1", sig_g, pass_g, GOOD8); end
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    poke  = 1'b0;
    test_reset();
    test_golden();
    test_faults();
    test_random();
    test_start_ignored();
    test_restart();
    test_back_to_back();
    test_clear_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
